circ_scratchpad: RTL and testbench

CIRC_SCRATCHPAD -- requirements
Module: circ_scratchpad

---
 rtl/csp_pkg.sv | 19 +
 rtl/csp_ram.sv | 38 +++
 rtl/circ_scratchpad.sv | 116 +++++++++++
 tb/tb_circ_scratchpad.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/csp_pkg.sv
// Shared defaults and pointer arithmetic for the circular scratchpad.
// Pointers are carried as 32-bit values here and narrowed by the caller.
package csp_pkg;

  localparam int CSP_DATA_WIDTH = 16;
  localparam int CSP_ADDR_WIDTH = 3;
  localparam int CSP_PAR_WRITE  = 2;
  localparam int CSP_PAR_READ   = 1;

  // (ptr + off) mod 2^aw
  function automatic logic [31:0] ptr_wrap(input logic [31:0] ptr,
                                           input logic [31:0] off,
                                           input int unsigned aw);
    logic [31:0] mask;
    mask = (32'd1 << aw) - 32'd1;
    return (ptr + off) & mask;
  endfunction

endpackage

// File: rtl/csp_ram.sv
// Scratchpad storage: PAR_WRITE words written per clock starting at waddr,
// PAR_READ words read combinationally starting at raddr. Not reset.
module csp_ram
  import csp_pkg::*;
#(
  parameter int DATA_WIDTH = CSP_DATA_WIDTH,
  parameter int ADDR_WIDTH = CSP_ADDR_WIDTH,
  parameter int PAR_WRITE  = CSP_PAR_WRITE,
  parameter int PAR_READ   = CSP_PAR_READ
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [ADDR_WIDTH-1:0]          waddr,
  input  logic [PAR_WRITE*DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0]          raddr,
  output logic [PAR_READ*DATA_WIDTH-1:0]  rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < PAR_WRITE; i++) begin
        mem[ADDR_WIDTH'(ptr_wrap(32'(waddr), 32'(i), ADDR_WIDTH))] <=
          wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Fall-through read: word j is the j-th oldest relative to raddr.
  for (genvar j = 0; j < PAR_READ; j++) begin : g_rd
    assign rdata[j*DATA_WIDTH +: DATA_WIDTH] =
      mem[ADDR_WIDTH'(ptr_wrap(32'(raddr), 32'(j), ADDR_WIDTH))];
  end

endmodule

// File: rtl/circ_scratchpad.sv
// Circular scratchpad with multi-word push / pop, pointer/count/flag logic.
// Define CSP_ERR_FLAG_EN to build the sticky protocol-violation flag (err).
module circ_scratchpad
  import csp_pkg::*;
#(
  parameter int DATA_WIDTH = CSP_DATA_WIDTH,
  parameter int ADDR_WIDTH = CSP_ADDR_WIDTH,
  parameter int PAR_WRITE  = CSP_PAR_WRITE,
  parameter int PAR_READ   = CSP_PAR_READ
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clear,
  input  logic                            wen,
  input  logic [PAR_WRITE*DATA_WIDTH-1:0] din,
  output logic                            wready,
  input  logic                            ren,
  output logic                            rvalid,
  output logic [PAR_READ*DATA_WIDTH-1:0]  dout,
  output logic [ADDR_WIDTH:0]             count,
  output logic                            full,
  output logic                            empty,
  output logic                            err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CNT_W = ADDR_WIDTH + 1;

  if (PAR_WRITE == 0 || PAR_READ == 0 || PAR_WRITE > DEPTH || PAR_READ > DEPTH) begin : g_bad_cfg
    $error("circ_scratchpad: PAR_WRITE/PAR_READ must be in 1..DEPTH");
  end

  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] WR_LIMIT  = CNT_W'(DEPTH - PAR_WRITE);
  localparam logic [CNT_W-1:0] PW_INC    = CNT_W'(PAR_WRITE);
  localparam logic [CNT_W-1:0] PR_DEC    = CNT_W'(PAR_READ);

  logic [ADDR_WIDTH-1:0] wptr, rptr;
  logic [ADDR_WIDTH-1:0] wptr_nxt, rptr_nxt;
  logic [CNT_W-1:0]      count_nxt;
  logic                  push_acc, pop_acc, ram_we;

  assign wready   = (count <= WR_LIMIT);
  assign rvalid   = (count >= PR_DEC);
  assign full     = (count == CNT_DEPTH);
  assign empty    = (count == '0);
  assign push_acc = wen && wready;
  assign pop_acc  = ren && rvalid;

  // Gating with rst_n drops a push that coincides with reset; clear wins too.
  assign ram_we   = push_acc && !clear && rst_n;

  always_comb begin
    wptr_nxt  = wptr;
    rptr_nxt  = rptr;
    count_nxt = count;
    if (clear) begin
      wptr_nxt  = '0;
      rptr_nxt  = '0;
      count_nxt = '0;
    end else begin
      if (push_acc) begin
        wptr_nxt = ADDR_WIDTH'(ptr_wrap(32'(wptr), 32'(PAR_WRITE), ADDR_WIDTH));
      end
      if (pop_acc) begin
        rptr_nxt = ADDR_WIDTH'(ptr_wrap(32'(rptr), 32'(PAR_READ), ADDR_WIDTH));
      end
      count_nxt = count + (push_acc ? PW_INC : '0) - (pop_acc ? PR_DEC : '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr_nxt;
      rptr  <= rptr_nxt;
      count <= count_nxt;
    end
  end

`ifdef CSP_ERR_FLAG_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (clear) begin
      err_q <= 1'b0;
    end else if ((wen && !wready) || (ren && !rvalid)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  csp_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .PAR_WRITE (PAR_WRITE),
    .PAR_READ  (PAR_READ)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(wptr),
    .wdata(din),
    .raddr(rptr),
    .rdata(dout)
  );

endmodule

// File: tb/tb_circ_scratchpad.sv
// Directed bench for circ_scratchpad at DEPTH=8, PAR_WRITE=2, PAR_READ=1.
module tb_circ_scratchpad;

  localparam int DW = 16;
  localparam int AW = 3;

`ifdef CSP_ERR_FLAG_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          clear;
  logic          wen;
  logic [2*DW-1:0] din;
  logic          wready;
  logic          ren;
  logic          rvalid;
  logic [DW-1:0] dout;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          err;

  int checks;
  int failures;

  circ_scratchpad #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .PAR_WRITE (2),
    .PAR_READ  (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .wen   (wen),
    .din   (din),
    .wready(wready),
    .ren   (ren),
    .rvalid(rvalid),
    .dout  (dout),
    .count (count),
    .full  (full),
    .empty (empty),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] hi, input logic [DW-1:0] lo);
    din = {hi, lo};
    wen = 1'b1;
    step();
    wen = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [DW-1:0] exp);
    chk(tag, 32'(dout), 32'(exp));
    ren = 1'b1;
    step();
    ren = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n = 1'b0;
    clear = 1'b0;
    wen   = 1'b0;
    ren   = 1'b0;
    din   = '0;
    #12;
    chk("rst_count",  32'(count),  32'd0);
    chk("rst_empty",  32'(empty),  32'd1);
    chk("rst_full",   32'(full),   32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_wready", 32'(wready), 32'd1);
    chk("rst_err",    32'(err),    32'd0);
    rst_n = 1'b1;
    step();

    // Basic push then pop
    push(16'h0002, 16'h0001);
    chk("b_count",  32'(count),  32'd2);
    chk("b_rvalid", 32'(rvalid), 32'd1);
    pop_chk("b_dout0", 16'h0001);
    chk("b_dout1",  32'(dout),  32'h0002);
    chk("b_count1", 32'(count), 32'd1);
    pop_chk("b_dout1p", 16'h0002);
    chk("b_empty", 32'(empty), 32'd1);

    // Fill to full, then a rejected push
    push(16'h0012, 16'h0011);
    push(16'h0014, 16'h0013);
    push(16'h0016, 16'h0015);
    push(16'h0018, 16'h0017);
    chk("f_count",  32'(count),  32'd8);
    chk("f_full",   32'(full),   32'd1);
    chk("f_wready", 32'(wready), 32'd0);
    chk("f_err0",   32'(err),    32'd0);
    push(16'h00FF, 16'h00FE);
    chk("f_count_rej", 32'(count), 32'd8);
    chk("f_err_rej",   32'(err),   32'(ERR_EN));
    for (int k = 0; k < 8; k++) begin
      pop_chk($sformatf("f_pop%0d", k), DW'(16'h0011 + k));
    end
    chk("f_empty", 32'(empty), 32'd1);
    chk("f_err_sticky", 32'(err), 32'(ERR_EN));
    // Rejected pop on empty
    ren = 1'b1;
    step();
    ren = 1'b0;
    chk("f_count_rpop", 32'(count), 32'd0);
    chk("f_err_rpop",   32'(err),   32'(ERR_EN));
    do_clear();
    chk("f_err_clr", 32'(err), 32'd0);

    // Wrap-around
    push(16'd2, 16'd1);
    push(16'd4, 16'd3);
    push(16'd6, 16'd5);
    for (int k = 1; k <= 5; k++) begin
      pop_chk($sformatf("w_pop%0d", k), DW'(k));
    end
    push(16'd8, 16'd7);
    push(16'd10, 16'd9);
    chk("w_count", 32'(count), 32'd5);
    for (int k = 6; k <= 10; k++) begin
      pop_chk($sformatf("w_pop%0d", k), DW'(k));
    end
    chk("w_count0", 32'(count), 32'd0);
    chk("w_empty",  32'(empty), 32'd1);

    // Simultaneous push and pop at count=6
    do_clear();
    push(16'h0022, 16'h0021);
    push(16'h0024, 16'h0023);
    push(16'h0026, 16'h0025);
    chk("s_count6", 32'(count),  32'd6);
    chk("s_wready", 32'(wready), 32'd1);
    din = {16'h0028, 16'h0027};
    wen = 1'b1;
    ren = 1'b1;
    step();
    wen = 1'b0;
    ren = 1'b0;
    chk("s_count7",  32'(count),  32'd7);
    chk("s_full",    32'(full),   32'd0);
    chk("s_wready7", 32'(wready), 32'd0);
    chk("s_dout",    32'(dout),   32'h0022);

    // clear beats push
    do_clear();
    push(16'h00A2, 16'h00A1);
    push(16'h00A4, 16'h00A3);
    chk("c_count4", 32'(count), 32'd4);
    din   = {16'h00BB, 16'h00BA};
    wen   = 1'b1;
    clear = 1'b1;
    step();
    wen   = 1'b0;
    clear = 1'b0;
    chk("c_count",  32'(count),  32'd0);
    chk("c_empty",  32'(empty),  32'd1);
    chk("c_rvalid", 32'(rvalid), 32'd0);
    step();
    chk("c_count_hold", 32'(count), 32'd0);
    push(16'h00C2, 16'h00C1);
    pop_chk("c_new0", 16'h00C1);
    chk("c_new1", 32'(dout), 32'h00C2);

    // Async reset between edges at count=5, with a push in flight
    do_clear();
    push(16'h0032, 16'h0031);
    push(16'h0034, 16'h0033);
    push(16'h0036, 16'h0035);
    pop_chk("r_pop", 16'h0031);
    chk("r_count5", 32'(count), 32'd5);
    din = {16'h0038, 16'h0037};
    wen = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("r_count",  32'(count),  32'd0);
    chk("r_empty",  32'(empty),  32'd1);
    chk("r_full",   32'(full),   32'd0);
    chk("r_rvalid", 32'(rvalid), 32'd0);
    chk("r_wready", 32'(wready), 32'd1);
    chk("r_err",    32'(err),    32'd0);
    #7;
    wen = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    chk("r_count_after", 32'(count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
